// File: rtl/product_bcd_converter_if.sv
// Handshake and result bundle between the multiplier-side controller and the BCD converter.
interface product_bcd_converter_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] product;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_hundreds;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;

  modport master (
    output start, product,
    input  busy, done, bcd_hundreds, bcd_tens, bcd_ones
  );

  modport slave (
    input  start, product,
    output busy, done, bcd_hundreds, bcd_tens, bcd_ones
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the multiplier product.
// Digit outputs are updated only when a conversion completes.
module product_bcd_converter #(
  parameter int WIDTH = 8
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  product_bcd_converter_if.slave   bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [3:0] STEPS = 4'(WIDTH);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [11:0]      scratch;
  logic [11:0]      scratch_adj;
  logic [11:0]      scratch_nxt;
  logic [3:0]       cnt;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       hundreds_r;
  logic [3:0]       tens_r;
  logic [3:0]       ones_r;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Digits are corrected independently before the shift; no inter-digit carry.
  always_comb begin
    scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    scratch_nxt = {scratch_adj[10:0], shreg[WIDTH-1]};
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      scratch    <= '0;
      cnt        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hundreds_r <= '0;
      tens_r     <= '0;
      ones_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            shreg   <= bus.product;
            scratch <= '0;
            cnt     <= STEPS;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          cnt     <= cnt - 4'd1;
          // Last step: publish the post-step scratch, never an intermediate value.
          if (cnt == 4'd1) begin
            hundreds_r <= scratch_nxt[11:8];
            tens_r     <= scratch_nxt[7:4];
            ones_r     <= scratch_nxt[3:0];
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.bcd_hundreds = hundreds_r;
  assign bus.bcd_tens     = tens_r;
  assign bus.bcd_ones     = ones_r;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: default 8-bit instance plus a 9-bit instance.
module tb_product_bcd_converter;

  typedef struct {
    logic [11:0] digits;
    int          acc;
  } exp_t;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q9[$];
  int   busy8 = 0;
  int   busy9 = 0;
  bit   held = 1'b0;
  int   last_done = -1;

  product_bcd_converter_if #(.WIDTH(8)) bus8 ();
  product_bcd_converter_if #(.WIDTH(9)) bus9 ();

  product_bcd_converter #(.WIDTH(8)) dut8 (.Clock(Clock), .Resetn(Resetn), .bus(bus8.slave));
  product_bcd_converter #(.WIDTH(9)) dut9 (.Clock(Clock), .Resetn(Resetn), .bus(bus9.slave));

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expectation on every done pulse.
  always @(negedge Clock) begin
    exp_t e;
    if (!Resetn) busy8 = 0;
    else begin
      if (bus8.busy) busy8 = busy8 + 1;
      if (bus8.done) begin
        if (q8.size() == 0) chk("unexpected_done8", 1, 0);
        else begin
          e = q8.pop_front();
          chk("digits8", int'({bus8.bcd_hundreds, bus8.bcd_tens, bus8.bcd_ones}), int'(e.digits));
          chk("latency8", cyc - e.acc, 8);
          chk("busy_cycles8", busy8, 8);
        end
        if (held && last_done >= 0) chk("done_period", cyc - last_done, 9);
        last_done = cyc;
        busy8 = 0;
      end
    end
  end

  always @(negedge Clock) begin
    exp_t e;
    if (!Resetn) busy9 = 0;
    else begin
      if (bus9.busy) busy9 = busy9 + 1;
      if (bus9.done) begin
        if (q9.size() == 0) chk("unexpected_done9", 1, 0);
        else begin
          e = q9.pop_front();
          chk("digits9", int'({bus9.bcd_hundreds, bus9.bcd_tens, bus9.bcd_ones}), int'(e.digits));
          chk("latency9", cyc - e.acc, 9);
          chk("busy_cycles9", busy9, 9);
        end
        busy9 = 0;
      end
    end
  end

  // Issue one start pulse to the 8-bit instance; product is scrambled after acceptance.
  task automatic conv8(input logic [7:0] val, input logic [11:0] digits);
    @(negedge Clock);
    bus8.start   = 1'b1;
    bus8.product = val;
    q8.push_back('{digits: digits, acc: cyc + 1});
    @(negedge Clock);
    bus8.start   = 1'b0;
    bus8.product = ~val;
  endtask

  task automatic conv9(input logic [8:0] val, input logic [11:0] digits);
    @(negedge Clock);
    bus9.start   = 1'b1;
    bus9.product = val;
    q9.push_back('{digits: digits, acc: cyc + 1});
    @(negedge Clock);
    bus9.start   = 1'b0;
    bus9.product = ~val;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (q8.size() > 0 || q9.size() > 0); i++) @(negedge Clock);
    chk(name, q8.size() + q9.size(), 0);
    repeat (3) @(negedge Clock);
  endtask

  logic [7:0]  held_vals [5] = '{8'd0, 8'd37, 8'd100, 8'd199, 8'd225};
  logic [11:0] held_exp  [5] = '{12'h000, 12'h037, 12'h100, 12'h199, 12'h225};

  initial begin
    bus8.start = 1'b0; bus8.product = '0;
    bus9.start = 1'b0; bus9.product = '0;
    #12;
    chk("reset_busy", int'(bus8.busy), 0);
    chk("reset_done", int'(bus8.done), 0);
    chk("reset_digits", int'({bus8.bcd_hundreds, bus8.bcd_tens, bus8.bcd_ones}), 0);
    chk("reset_digits9", int'({bus9.bcd_hundreds, bus9.bcd_tens, bus9.bcd_ones}), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    conv8(8'd225, 12'h225); drain("drain_225");
    conv8(8'd0,   12'h000); drain("drain_0");
    conv8(8'd255, 12'h255); drain("drain_255");

    // A start during SHIFT must be ignored.
    conv8(8'd99, 12'h099);
    bus8.start = 1'b1; bus8.product = 8'd7;
    @(negedge Clock);
    chk("busy_during_ignore", int'(bus8.busy), 1);
    bus8.start = 1'b0;
    drain("drain_99");

    // start held high: back-to-back conversions every 9 clocks.
    held = 1'b1; last_done = -1;
    @(negedge Clock);
    bus8.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        int k;
        for (k = 0; k < 12; k++) begin
          @(negedge Clock);
          if (bus8.done) break;
        end
        if (k == 12) chk("held_timeout", 1, 0);
      end
      bus8.product = held_vals[i];
      q8.push_back('{digits: held_exp[i], acc: cyc + 1});
    end
    @(negedge Clock);
    bus8.start = 1'b0;
    drain("drain_held");
    held = 1'b0;

    // Asynchronous reset after the 4th step aborts the conversion silently.
    conv8(8'd144, 12'h144);
    repeat (4) @(negedge Clock);
    Resetn = 1'b0;
    q8.delete();
    #1;
    chk("abort_busy", int'(bus8.busy), 0);
    chk("abort_done", int'(bus8.done), 0);
    chk("abort_digits", int'({bus8.bcd_hundreds, bus8.bcd_tens, bus8.bcd_ones}), 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (12) @(negedge Clock);
    chk("no_done_after_abort_busy", int'(bus8.busy), 0);
    conv8(8'd144, 12'h144); drain("drain_144");

    conv9(9'd511, 12'h511); drain("drain_511");
    conv9(9'd300, 12'h300); drain("drain_300");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
